// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the byte-addressed ROM and
// buffers fetched words in a circular queue handed to issue via valid/ready.
module fetch_ctrl #(
    parameter int          DEPTH     = 4,
    parameter int          ROM_BYTES = 100,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rom_nrd,
    output logic [31:0]                rom_addr,
    input  logic [31:0]                rom_data,
    output logic                       inst_valid,
    output logic [31:0]                inst,
    output logic [31:0]                inst_pc,
    input  logic                       inst_ready,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Two-state FSM; the state is visible on the halted output.
    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HALT  = 1'b1;

    // Handshake: the head entry transfers on a cycle where inst_valid and
    // inst_ready are both high; inst/inst_pc hold steady until that happens.
    logic [0:0]    state;
    logic [31:0]   pc;
    logic [31:0]   pc_next;
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          full;
    logic          pop;
    logic          fetch_en;

    // 33-bit sum so a PC near 2^32 cannot wrap into the legal range.
    function automatic logic legal_fetch(input logic [31:0] a);
        return ({1'b0, a} + 33'd3) <= 33'(ROM_BYTES - 1);
    endfunction

    assign pc_next  = pc + 32'd4;
    assign full     = (cnt == CW'(DEPTH));
    assign pop      = inst_valid & inst_ready;
    assign fetch_en = (state == FETCH) & ~redirect & ~rst & (~full | pop);

    assign rom_nrd    = ~fetch_en;
    assign rom_addr   = pc;
    assign inst_valid = (cnt != '0);
    assign inst       = inst_valid ? q_inst[head] : 32'd0;
    assign inst_pc    = inst_valid ? q_pc[head]   : 32'd0;
    assign count      = cnt;
    assign halted     = (state == HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
        end else if (redirect) begin
            state <= legal_fetch(redirect_pc) ? FETCH : HALT;
            pc    <= redirect_pc;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
        end else begin
            if (fetch_en) begin
                pc   <= pc_next;
                tail <= tail + AW'(1);
                if (!legal_fetch(pc_next)) begin
                    state <= HALT;
                end
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            // A push and pop in the same cycle leave occupancy unchanged.
            if (fetch_en && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (!fetch_en && pop) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Queue storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (fetch_en) begin
            q_inst[tail] <= rom_data;
            q_pc[tail]   <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based model of the fetch unit.
module tb_fetch_ctrl;

    localparam int DEPTH     = 4;
    localparam int ROM_BYTES = 100;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rom_nrd;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [$clog2(DEPTH):0] count;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [7:0]  rom_mem [ROM_BYTES];
    logic [63:0] exp_q [$];
    logic [31:0] m_pc;
    logic        m_halt;

    fetch_ctrl #(.DEPTH(DEPTH), .ROM_BYTES(ROM_BYTES), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .rom_nrd(rom_nrd), .rom_addr(rom_addr),
        .rom_data(rom_data), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .count(count), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] w;
        longint idx;
        w = 32'd0;
        for (int k = 0; k < 4; k++) begin
            idx = longint'({32'd0, a}) + k;
            w = {w[23:0], (idx < ROM_BYTES) ? rom_mem[idx] : 8'h00};
        end
        return w;
    endfunction

    always_comb rom_data = rom_word(rom_addr);

    function automatic logic m_legal(input logic [31:0] a);
        return ({32'd0, a} + 64'd3) <= 64'(ROM_BYTES - 1);
    endfunction

    function automatic logic m_fetch();
        return !rst && !redirect && !m_halt &&
               (exp_q.size() < DEPTH || (exp_q.size() > 0 && inst_ready));
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic r, input logic rdy, input logic rd,
                         input logic [31:0] rpc);
        @(negedge clk);
        rst = r;
        inst_ready = rdy;
        redirect = rd;
        redirect_pc = rpc;
        #1;
    endtask

    // Advance the model by one rising edge using the inputs now applied.
    task automatic commit();
        logic do_fetch;
        do_fetch = m_fetch();
        if (rst) begin
            exp_q.delete();
            m_pc = RESET_PC;
            m_halt = 1'b0;
        end else if (redirect) begin
            exp_q.delete();
            m_pc = redirect_pc;
            m_halt = !m_legal(redirect_pc);
        end else begin
            if (exp_q.size() > 0 && inst_ready) void'(exp_q.pop_front());
            if (do_fetch) begin
                exp_q.push_back({rom_word(m_pc), m_pc});
                m_pc = m_pc + 32'd4;
                if (!m_legal(m_pc)) m_halt = 1'b1;
            end
        end
    endtask

    task automatic apply_reset();
        drive(1'b1, 1'b0, 1'b0, 32'd0); commit();
        drive(1'b1, 1'b0, 1'b0, 32'd0); commit();
    endtask

    task automatic test_reset();
        apply_reset();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", inst_valid); end
        checks++; if (count !== 0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got=%0b exp=0", halted); end
        checks++; if ({inst, inst_pc} !== 64'd0) begin errors++; $display("FAIL rst_head got=%h/%h exp=0/0", inst, inst_pc); end
        checks++; if (rom_nrd !== 1'b0 || rom_addr !== 32'd0) begin errors++; $display("FAIL rst_fetch0 nrd=%0b addr=%0d exp 0/0", rom_nrd, rom_addr); end
        commit();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        checks++; if (inst !== 32'h11121314 || inst_pc !== 32'd0) begin errors++; $display("FAIL rst_c1 got=%h@%0d exp=11121314@0", inst, inst_pc); end
        commit();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        checks++; if (inst !== 32'h15161718 || inst_pc !== 32'd4) begin errors++; $display("FAIL rst_c2 got=%h@%0d exp=15161718@4", inst, inst_pc); end
        commit();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        checks++; if (inst !== 32'h191A1B1C || inst_pc !== 32'd8) begin errors++; $display("FAIL rst_c3 got=%h@%0d exp=191a1b1c@8", inst, inst_pc); end
        commit();
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0); commit();
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++; if (count !== 4 || rom_nrd !== 1'b1 || rom_addr !== 32'd16) begin errors++; $display("FAIL full_stall cnt=%0d nrd=%0b addr=%0d exp 4/1/16", count, rom_nrd, rom_addr); end
        commit();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        checks++; if (rom_nrd !== 1'b0 || inst_pc !== 32'd0) begin errors++; $display("FAIL full_pushpop nrd=%0b head=%0d exp 0/0", rom_nrd, inst_pc); end
        commit();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++; if (count !== 4 || inst_pc !== 32'd4 || rom_addr !== 32'd20) begin errors++; $display("FAIL full_after cnt=%0d head=%0d addr=%0d exp 4/4/20", count, inst_pc, rom_addr); end
        commit();
    endtask

    task automatic test_redirect();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0); commit();
        end
        drive(1'b0, 1'b0, 1'b1, 32'd40);
        checks++; if (count !== 3 || rom_nrd !== 1'b1) begin errors++; $display("FAIL redir_cycle cnt=%0d nrd=%0b exp 3/1", count, rom_nrd); end
        commit();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++; if (count !== 0 || inst_valid !== 1'b0 || rom_addr !== 32'd40) begin errors++; $display("FAIL redir_flush cnt=%0d v=%0b addr=%0d exp 0/0/40", count, inst_valid, rom_addr); end
        commit();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++; if (inst_pc !== 32'd40 || inst !== rom_word(32'd40)) begin errors++; $display("FAIL redir_head got=%h@%0d exp=%h@40", inst, inst_pc, rom_word(32'd40)); end
        commit();
    endtask

    task automatic test_end_of_rom();
        logic [31:0] last;
        logic hit;
        apply_reset();
        last = 32'hFFFF_FFFF;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'd0);
            if (rom_nrd === 1'b0) last = rom_addr;
            hit = (halted === 1'b1);
            commit();
        end
        checks++; if (!hit) begin errors++; $display("FAIL eor_timeout halted never rose within 60 cycles"); end
        checks++; if (last !== 32'd96) begin errors++; $display("FAIL eor_last got=%0d exp=96", last); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'd0);
            checks++; if (rom_nrd !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL eor_hold nrd=%0b halted=%0b exp 1/1", rom_nrd, halted); end
            commit();
        end
        drive(1'b0, 1'b1, 1'b1, 32'd8); commit();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        checks++; if (halted !== 1'b0 || rom_nrd !== 1'b0 || rom_addr !== 32'd8) begin errors++; $display("FAIL eor_resume h=%0b nrd=%0b addr=%0d exp 0/0/8", halted, rom_nrd, rom_addr); end
        commit();
        drive(1'b0, 1'b1, 1'b1, 32'd97); commit();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        checks++; if (halted !== 1'b1 || rom_nrd !== 1'b1 || rom_addr !== 32'd97) begin errors++; $display("FAIL eor_bad h=%0b nrd=%0b addr=%0d exp 1/1/97", halted, rom_nrd, rom_addr); end
        commit();
    endtask

    task automatic test_redirect_pop();
        apply_reset();
        drive(1'b0, 1'b0, 1'b0, 32'd0); commit();
        drive(1'b0, 1'b0, 1'b0, 32'd0); commit();
        drive(1'b0, 1'b1, 1'b1, 32'd26);
        checks++; if (inst_valid !== 1'b1 || rom_nrd !== 1'b1) begin errors++; $display("FAIL rpop_cycle v=%0b nrd=%0b exp 1/1", inst_valid, rom_nrd); end
        commit();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++; if (count !== 0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rpop_flush cnt=%0d v=%0b exp 0/0", count, inst_valid); end
        commit();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++; if (inst_pc !== 32'd26 || count !== 1) begin errors++; $display("FAIL rpop_head pc=%0d cnt=%0d exp 26/1", inst_pc, count); end
        commit();
    endtask

    task automatic test_rst_mid();
        apply_reset();
        drive(1'b0, 1'b0, 1'b0, 32'd0); commit();
        drive(1'b0, 1'b0, 1'b0, 32'd0); commit();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'd0); commit();
        end
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        checks++; if (count !== 2 || rom_addr !== 32'd20 || rom_nrd !== 1'b1) begin errors++; $display("FAIL rstmid_pre cnt=%0d addr=%0d nrd=%0b exp 2/20/1", count, rom_addr, rom_nrd); end
        commit();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        checks++; if (count !== 0 || rom_addr !== RESET_PC || halted !== 1'b0 || rom_nrd !== 1'b0) begin errors++; $display("FAIL rstmid_post cnt=%0d addr=%0d h=%0b nrd=%0b exp 0/0/0/0", count, rom_addr, halted, rom_nrd); end
        commit();
    endtask

    task automatic test_random();
        logic r, rd;
        logic [31:0] rpc;
        logic [31:0] e_inst, e_pc;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 79) == 0);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = $urandom_range(0, 110);
            drive(r, 1'($urandom_range(0, 2) != 0), rd, rpc);
            e_inst = (exp_q.size() > 0) ? exp_q[0][63:32] : 32'd0;
            e_pc   = (exp_q.size() > 0) ? exp_q[0][31:0]  : 32'd0;
            checks++;
            if (count !== ($clog2(DEPTH) + 1)'(exp_q.size()) || inst_valid !== (exp_q.size() > 0) ||
                inst !== e_inst || inst_pc !== e_pc || rom_addr !== m_pc ||
                halted !== m_halt || rom_nrd !== !m_fetch()) begin
                errors++;
                $display("FAIL rand_cyc%0d got cnt=%0d v=%0b %h@%0d addr=%0d h=%0b nrd=%0b exp cnt=%0d %h@%0d addr=%0d h=%0b nrd=%0b",
                         i, count, inst_valid, inst, inst_pc, rom_addr, halted, rom_nrd,
                         exp_q.size(), e_inst, e_pc, m_pc, m_halt, !m_fetch());
            end
            commit();
        end
    endtask

    initial begin
        for (int i = 0; i < ROM_BYTES; i++) rom_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 12; i++) rom_mem[i] = 8'(8'h11 + i);
        m_pc = RESET_PC;
        m_halt = 1'b0;
        test_reset();
        test_full();
        test_redirect();
        test_end_of_rom();
        test_redirect_pop();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
